// File: rtl/knc_chunk_server.sv
// Key/nonce/counter word store that serves one 32-bit chunk per request.
// A host write port loads the store; a request port reads it back one word at a time.
module knc_chunk_server (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_host_wr_valid,
   output logic        o_host_wr_ready,
   input  logic [1:0]  i_host_wr_type,
   input  logic [2:0]  i_host_wr_index,
   input  logic [31:0] i_host_wr_data,
   input  logic        i_clear,
   input  logic        i_auto_inc,
   input  logic        i_chunk_request,
   input  logic [1:0]  i_request_type,
   input  logic [4:0]  i_chunk_index,
   output logic [31:0] o_chunk,
   output logic [1:0]  o_chunk_type,
   output logic        o_chunk_valid,
   output logic        o_key_loaded,
   output logic        o_nonce_loaded,
   output logic        o_counter_loaded,
   output logic        o_err_sticky,
   output logic        o_counter_wrap
);

   localparam logic [1:0] TYPE_KEY   = 2'b00;
   localparam logic [1:0] TYPE_NONCE = 2'b01;
   localparam logic [1:0] TYPE_CTR   = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_SERVE, S_HOLD} state_t;

   state_t       r_state;
   logic [255:0] r_key;
   logic [95:0]  r_nonce;
   logic [31:0]  r_counter;
   logic [7:0]   r_key_mask;
   logic [2:0]   r_nonce_mask;
   logic         r_counter_mask;
   logic [1:0]   r_lat_type;
   logic [4:0]   r_lat_idx;
   logic         r_rej_valid;
   logic [1:0]   r_rej_type;
   logic [4:0]   r_rej_idx;
   logic [31:0]  r_chunk;
   logic [1:0]   r_chunk_type;
   logic         r_chunk_valid;
   logic         r_err;
   logic         r_wrap;

   logic         w_req_legal;
   logic [31:0]  w_req_word;
   logic         w_wr_legal;
   logic         w_same_req;
   logic         w_rej_same;

   // Request lookup: legal only if the index is in range and that word was written.
   always_comb begin
      // NOTE: defaults first so every path assigns every signal and no latch is inferred.
      w_req_legal = 1'b0;
      w_req_word  = '0;
      case (i_request_type)
         TYPE_KEY: if (i_chunk_index < 5'd8) begin
            w_req_legal = r_key_mask[i_chunk_index[2:0]];
            w_req_word  = r_key[{i_chunk_index[2:0], 5'd0} +: 32];
         end
         TYPE_NONCE: if (i_chunk_index < 5'd3) begin
            w_req_legal = r_nonce_mask[i_chunk_index[1:0]];
            w_req_word  = r_nonce[{i_chunk_index[1:0], 5'd0} +: 32];
         end
         TYPE_CTR: if (i_chunk_index == 5'd0) begin
            w_req_legal = r_counter_mask;
            w_req_word  = r_counter;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_wr_legal = 1'b0;
      case (i_host_wr_type)
         TYPE_KEY:   w_wr_legal = 1'b1;
         TYPE_NONCE: w_wr_legal = (i_host_wr_index < 3'd3);
         TYPE_CTR:   w_wr_legal = (i_host_wr_index == 3'd0);
         default:    w_wr_legal = 1'b0;
      endcase
   end

   assign w_same_req = (i_request_type == r_lat_type) && (i_chunk_index == r_lat_idx);
   assign w_rej_same = r_rej_valid && (i_request_type == r_rej_type) && (i_chunk_index == r_rej_idx);

   assign o_host_wr_ready  = (r_state == S_IDLE) && !i_chunk_request && !i_clear && !i_rst;
   assign o_chunk          = r_chunk;
   assign o_chunk_type     = r_chunk_type;
   assign o_chunk_valid    = r_chunk_valid;
   assign o_key_loaded     = &r_key_mask;
   assign o_nonce_loaded   = &r_nonce_mask;
   assign o_counter_loaded = r_counter_mask;
   assign o_err_sticky     = r_err;
   assign o_counter_wrap   = r_wrap;

   always_ff @(posedge i_clk) begin
      // NOTE: the word store is cleared here too, since clear and reset must both zero it.
      if (i_rst || i_clear) begin
         r_state        <= S_IDLE;
         r_key          <= '0;
         r_nonce        <= '0;
         r_counter      <= '0;
         r_key_mask     <= '0;
         r_nonce_mask   <= '0;
         r_counter_mask <= 1'b0;
         r_lat_type     <= '0;
         r_lat_idx      <= '0;
         r_rej_valid    <= 1'b0;
         r_rej_type     <= '0;
         r_rej_idx      <= '0;
         r_chunk        <= '0;
         r_chunk_type   <= '0;
         r_chunk_valid  <= 1'b0;
         r_err          <= 1'b0;
         r_wrap         <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_chunk_request) begin
                  if (w_req_legal) begin
                     r_state       <= S_SERVE;
                     r_lat_type    <= i_request_type;
                     r_lat_idx     <= i_chunk_index;
                     r_chunk       <= w_req_word;
                     r_chunk_type  <= i_request_type;
                     r_chunk_valid <= 1'b1;
                     r_rej_valid   <= 1'b0;
                  end else if (!w_rej_same) begin
                     // Flag an illegal request once; it re-arms when the request changes or drops.
                     r_err       <= 1'b1;
                     r_rej_valid <= 1'b1;
                     r_rej_type  <= i_request_type;
                     r_rej_idx   <= i_chunk_index;
                  end
               end else begin
                  r_rej_valid <= 1'b0;
                  if (i_host_wr_valid) begin
                     if (w_wr_legal) begin
                        case (i_host_wr_type)
                           TYPE_KEY: begin
                              r_key[{i_host_wr_index, 5'd0} +: 32] <= i_host_wr_data;
                              r_key_mask[i_host_wr_index]          <= 1'b1;
                           end
                           TYPE_NONCE: begin
                              r_nonce[{i_host_wr_index[1:0], 5'd0} +: 32] <= i_host_wr_data;
                              r_nonce_mask[i_host_wr_index[1:0]]          <= 1'b1;
                           end
                           default: begin
                              r_counter      <= i_host_wr_data;
                              r_counter_mask <= 1'b1;
                           end
                        endcase
                     end else begin
                        r_err <= 1'b1;
                     end
                  end
               end
            end
            S_SERVE: begin
               r_chunk_valid <= 1'b0;
               r_state       <= S_HOLD;
               // The served value was captured before this edge, so the bump is post-serve.
               if (i_auto_inc && (r_lat_type == TYPE_CTR)) begin
                  r_counter <= r_counter + 32'd1;
                  if (&r_counter)
                     r_wrap <= 1'b1;
               end
            end
            S_HOLD: begin
               if (!i_chunk_request || !w_same_req)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_knc_chunk_server.sv
// Bench for knc_chunk_server: directed scenarios plus random traffic, all outputs
// compared every cycle against a word-table model of the chunk server.
module tb_knc_chunk_server;

   logic        clk = 1'b0;
   logic        rst;
   logic        host_wr_valid;
   logic        host_wr_ready;
   logic [1:0]  host_wr_type;
   logic [2:0]  host_wr_index;
   logic [31:0] host_wr_data;
   logic        clear;
   logic        auto_inc;
   logic        chunk_request;
   logic [1:0]  request_type;
   logic [4:0]  chunk_index;
   logic [31:0] chunk;
   logic [1:0]  chunk_type;
   logic        chunk_valid;
   logic        key_loaded;
   logic        nonce_loaded;
   logic        counter_loaded;
   logic        err_sticky;
   logic        counter_wrap;

   always #5 clk = ~clk;

   knc_chunk_server dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_host_wr_valid  (host_wr_valid),
      .o_host_wr_ready  (host_wr_ready),
      .i_host_wr_type   (host_wr_type),
      .i_host_wr_index  (host_wr_index),
      .i_host_wr_data   (host_wr_data),
      .i_clear          (clear),
      .i_auto_inc       (auto_inc),
      .i_chunk_request  (chunk_request),
      .i_request_type   (request_type),
      .i_chunk_index    (chunk_index),
      .o_chunk          (chunk),
      .o_chunk_type     (chunk_type),
      .o_chunk_valid    (chunk_valid),
      .o_key_loaded     (key_loaded),
      .o_nonce_loaded   (nonce_loaded),
      .o_counter_loaded (counter_loaded),
      .o_err_sticky     (err_sticky),
      .o_counter_wrap   (counter_wrap)
   );

   int n_vec    = 0;
   int n_bad    = 0;
   int n_pulses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a table of words per element type, plus "serving" and "holding" flags.
   logic [31:0] m_word [3][8];
   bit          m_have [3][8];
   int          m_size [3] = '{8, 3, 1};
   bit          m_started, m_serving, m_holding, m_err, m_wrap, m_rej_valid;
   logic [1:0]  m_srv_type, m_rej_type, m_ctype;
   logic [4:0]  m_srv_idx, m_rej_idx;
   logic [31:0] m_chunk;

   function automatic bit m_word_present(input logic [1:0] t, input logic [4:0] idx);
      if (t == 2'b11) return 1'b0;
      if (int'(idx) >= m_size[t]) return 1'b0;
      return m_have[t][idx];
   endfunction

   function automatic bit m_loaded(input int t);
      for (int i = 0; i < m_size[t]; i++)
         if (!m_have[t][i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int t = 0; t < 3; t++)
         for (int i = 0; i < 8; i++) begin
            m_word[t][i] = '0;
            m_have[t][i] = 1'b0;
         end
      m_serving = 0; m_holding = 0; m_err = 0; m_wrap = 0; m_rej_valid = 0;
      m_chunk = '0; m_ctype = '0;
   endtask

   always @(posedge clk) begin
      if (rst || clear) begin
         model_reset();
         m_started = 1'b1;
      end else if (m_serving) begin
         m_serving = 0;
         m_holding = 1;
         if (auto_inc && m_srv_type == 2'd2) begin
            if (m_word[2][0] == 32'hFFFF_FFFF) m_wrap = 1;
            m_word[2][0] = m_word[2][0] + 32'd1;
         end
      end else if (m_holding) begin
         if (!chunk_request || request_type != m_srv_type || chunk_index != m_srv_idx)
            m_holding = 0;
      end else if (chunk_request) begin
         if (m_word_present(request_type, chunk_index)) begin
            m_serving   = 1;
            m_srv_type  = request_type;
            m_srv_idx   = chunk_index;
            m_chunk     = m_word[request_type][chunk_index[2:0]];
            m_ctype     = request_type;
            m_rej_valid = 0;
         end else if (!(m_rej_valid && m_rej_type == request_type && m_rej_idx == chunk_index)) begin
            m_err       = 1;
            m_rej_valid = 1;
            m_rej_type  = request_type;
            m_rej_idx   = chunk_index;
         end
      end else begin
         m_rej_valid = 0;
         if (host_wr_valid) begin
            if (host_wr_type != 2'b11 && int'(host_wr_index) < m_size[host_wr_type]) begin
               m_word[host_wr_type][host_wr_index] = host_wr_data;
               m_have[host_wr_type][host_wr_index] = 1'b1;
            end else begin
               m_err = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         check("ready", host_wr_ready,
               !m_serving && !m_holding && !chunk_request && !clear && !rst);
         check("chunk_valid", chunk_valid, m_serving);
         check("chunk", chunk, m_chunk);
         check("chunk_type", chunk_type, m_ctype);
         check("key_loaded", key_loaded, m_loaded(0));
         check("nonce_loaded", nonce_loaded, m_loaded(1));
         check("counter_loaded", counter_loaded, m_loaded(2));
         check("err_sticky", err_sticky, m_err);
         check("counter_wrap", counter_wrap, m_wrap);
         if (chunk_valid) n_pulses++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] t, input logic [2:0] idx, input logic [31:0] d);
      host_wr_valid = 1; host_wr_type = t; host_wr_index = idx; host_wr_data = d;
      tick();
      host_wr_valid = 0;
   endtask

   // Request one word, expect a single pulse the cycle after, then release.
   task automatic serve(input logic [1:0] t, input logic [4:0] idx, input logic [31:0] exp);
      chunk_request = 1; request_type = t; chunk_index = idx;
      tick();
      check("lit_serve_valid", chunk_valid, 1'b1);
      check("lit_serve_chunk", chunk, exp);
      check("lit_serve_type", chunk_type, t);
      tick();
      check("lit_serve_one_pulse", chunk_valid, 1'b0);
      chunk_request = 0;
      tick();
   endtask

   logic [31:0] kw [4] = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0102_0304, 32'h0506_0708};
   logic [31:0] nw [3] = '{32'hFEDC_BA98, 32'h9ABC_DEF0, 32'h1234_5678};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      bit seen;
      rst = 1; clear = 0; auto_inc = 0; host_wr_valid = 0; host_wr_type = 0;
      host_wr_index = 0; host_wr_data = 0; chunk_request = 0; request_type = 0; chunk_index = 0;
      tick(); tick();
      rst = 0;
      tick();
      check("lit_rst_chunk", chunk, 32'h0);
      check("lit_rst_valid", chunk_valid, 1'b0);
      check("lit_rst_loaded", {key_loaded, nonce_loaded, counter_loaded}, 3'b000);
      check("lit_rst_ready", host_wr_ready, 1'b1);

      // Illegal requests before any write.
      p0 = n_pulses;
      chunk_request = 1; request_type = 2'd1; chunk_index = 5'd3; repeat (3) tick();
      request_type = 2'd3; chunk_index = 5'd0; repeat (2) tick();
      request_type = 2'd0; chunk_index = 5'd0; repeat (2) tick();
      chunk_request = 0; tick();
      check("lit_illegal_pulses", n_pulses - p0, 0);
      check("lit_illegal_err", err_sticky, 1'b1);
      clear = 1; tick(); clear = 0; tick();
      check("lit_clear_err", err_sticky, 1'b0);

      // Full load and read-back of every key word.
      for (int i = 0; i < 8; i++) wr(2'd0, 3'(i), kw[i % 4]);
      for (int i = 0; i < 3; i++) wr(2'd1, 3'(i), nw[i]);
      wr(2'd2, 3'd0, 32'hA0B0_C0D0);
      tick();
      check("lit_all_loaded", {key_loaded, nonce_loaded, counter_loaded}, 3'b111);
      for (int i = 0; i < 8; i++) serve(2'd0, 5'(i), kw[i % 4]);
      serve(2'd1, 5'd2, 32'h1234_5678);
      serve(2'd2, 5'd0, 32'hA0B0_C0D0);

      // A held request produces a single pulse.
      p0 = n_pulses;
      chunk_request = 1; request_type = 2'd0; chunk_index = 5'd3;
      repeat (10) tick();
      chunk_request = 0; tick();
      check("lit_hold_pulses", n_pulses - p0, 1);
      check("lit_hold_chunk", chunk, 32'h0506_0708);

      // Write while a request is pending waits until the request drops.
      chunk_request = 1; request_type = 2'd0; chunk_index = 5'd1;
      host_wr_valid = 1; host_wr_type = 2'd1; host_wr_index = 3'd0; host_wr_data = 32'h1111_2222;
      tick();
      check("lit_busy_ready", host_wr_ready, 1'b0);
      tick();
      chunk_request = 0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (host_wr_ready) seen = 1;
         tick();
         if (seen) break;
      end
      host_wr_valid = 0;
      check("lit_wr_accepted", seen, 1'b1);
      serve(2'd1, 5'd0, 32'h1111_2222);

      // Counter auto-increment across the wrap point.
      auto_inc = 1;
      wr(2'd2, 3'd0, 32'hFFFF_FFFF);
      serve(2'd2, 5'd0, 32'hFFFF_FFFF);
      serve(2'd2, 5'd0, 32'h0000_0000);
      check("lit_wrap", counter_wrap, 1'b1);
      serve(2'd2, 5'd0, 32'h0000_0001);
      auto_inc = 0;

      // Reset, then clear, while serving.
      chunk_request = 1; request_type = 2'd0; chunk_index = 5'd0;
      tick();
      rst = 1; tick();
      check("lit_rst_mid_valid", chunk_valid, 1'b0);
      check("lit_rst_mid_chunk", chunk, 32'h0);
      check("lit_rst_mid_flags", {key_loaded, err_sticky, counter_wrap}, 3'b000);
      rst = 0; chunk_request = 0;
      #1;
      check("lit_rst_mid_ready", host_wr_ready, 1'b1);
      tick();
      wr(2'd0, 3'd0, 32'h1234_5678);
      p0 = n_pulses;
      chunk_request = 1; request_type = 2'd0; chunk_index = 5'd0; clear = 1;
      tick();
      clear = 0; chunk_request = 0; tick();
      check("lit_clear_no_pulse", n_pulses - p0, 0);
      check("lit_clear_chunk", chunk, 32'h0);
      wr(2'd0, 3'd0, 32'h1234_5678);
      chunk_request = 1; tick();
      clear = 1; tick();
      check("lit_clear_serve_valid", chunk_valid, 1'b0);
      check("lit_clear_serve_type", chunk_type, 2'b00);
      clear = 0; chunk_request = 0; tick();

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            chunk_request = ($urandom_range(0, 2) == 0);
            request_type  = 2'($urandom_range(0, 3));
            chunk_index   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31))
                                                        : 5'($urandom_range(0, 7));
         end
         host_wr_valid = ($urandom_range(0, 1) == 1);
         host_wr_type  = 2'($urandom_range(0, 3));
         host_wr_index = 3'($urandom_range(0, 7));
         host_wr_data  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         auto_inc      = ($urandom_range(0, 1) == 1);
         clear         = ($urandom_range(0, 149) == 0);
         rst           = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 0; clear = 0; chunk_request = 0; host_wr_valid = 0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
